// File: rtl/wbq_pkg.sv
// -----------------------------------------------------------------------------
// wbq_pkg
// Shared widths and the FIFO entry type for the writeback write queue.
//   XLEN        : register data width
//   REG_AW      : register address width
//   wbq_entry_t : one queued long-latency result {rd, wd}
// Optional feature macro used by this slice: WBQ_BYPASS_EN (see wb_write_queue).
// -----------------------------------------------------------------------------
package wbq_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_fifo.sv
// -----------------------------------------------------------------------------
// wbq_fifo
// DEPTH-entry circular buffer holding long-latency results until the
// register-file write port has a free slot.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   push, push_entry: enqueue (caller guarantees !full)
//   pop             : dequeue head (caller guarantees !empty)
//   head            : current oldest entry
//   count/full/empty: occupancy status (registered)
//   age_entries/age_valid (only with WBQ_BYPASS_EN): entries ordered oldest
//                    (index 0) to youngest, with a per-slot valid mask, for the
//                    bypass search in the top level.
// -----------------------------------------------------------------------------
module wbq_fifo
  import wbq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  wbq_entry_t                   push_entry,
  input  logic                         pop,
  output wbq_entry_t                   head,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
`ifdef WBQ_BYPASS_EN
  ,
  output wbq_entry_t [DEPTH-1:0]       age_entries,
  output logic       [DEPTH-1:0]       age_valid
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  wbq_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;

  // Storage needs no reset: validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= push_entry;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

`ifdef WBQ_BYPASS_EN
  // Age-ordered view: slot gi is the gi-th oldest entry.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_age
      logic [PTR_W-1:0] slot;
      assign slot            = rd_ptr_reg + PTR_W'(gi);
      assign age_entries[gi] = mem[slot];
      assign age_valid[gi]   = (CNT_W'(gi) < count_reg);
    end
  endgenerate
`endif

endmodule

// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
// Sole writer of the register-file write port (WE3/A3/WD3). Merges the
// in-order pipeline writeback (no backpressure, highest priority) with a
// long-latency result stream (valid/ready) that is buffered in a FIFO and
// drained in idle writeback slots. Writes to x0 are discarded from both
// sources. A starvation counter raises a one-cycle pipe_stall so the FIFO
// head is guaranteed a slot.
// Ports:
//   clk, rst                 : clock, asynchronous active-low reset
//   pipe_we/pipe_rd/pipe_wd  : pipeline writeback request
//   mc_valid/mc_ready        : long-latency handshake (mc_ready = !q_full)
//   mc_rd/mc_wd              : long-latency destination and result
//   pipe_stall               : upstream must hold pipe_we=0 next cycle
//   WE3/A3/WD3               : registered register-file write port
//   q_count/q_full/q_empty   : FIFO status
// Optional (macro WBQ_BYPASS_EN):
//   byp_a1/byp_a2            : lookup addresses
//   byp1_hit/byp2_hit        : some queued entry targets that address
//   byp1_data/byp2_data      : data of the youngest matching entry
// -----------------------------------------------------------------------------
module wb_write_queue
  import wbq_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pipe_we,
  input  logic [REG_AW-1:0]            pipe_rd,
  input  logic [XLEN-1:0]              pipe_wd,
  input  logic                         mc_valid,
  output logic                         mc_ready,
  input  logic [REG_AW-1:0]            mc_rd,
  input  logic [XLEN-1:0]              mc_wd,
  output logic                         pipe_stall,
  output logic                         WE3,
  output logic [REG_AW-1:0]            A3,
  output logic [XLEN-1:0]              WD3,
  output logic [$clog2(DEPTH+1)-1:0]   q_count,
  output logic                         q_full,
  output logic                         q_empty
`ifdef WBQ_BYPASS_EN
  ,
  input  logic [REG_AW-1:0]            byp_a1,
  input  logic [REG_AW-1:0]            byp_a2,
  output logic                         byp1_hit,
  output logic                         byp2_hit,
  output logic [XLEN-1:0]              byp1_data,
  output logic [XLEN-1:0]              byp2_data
`endif
);

  localparam int SW = $clog2(STARVE_MAX+1);

  logic       pipe_win;
  logic       push;
  logic       pop;
  wbq_entry_t push_entry;
  wbq_entry_t head;
  logic [SW-1:0] starve_cnt_reg;

`ifdef WBQ_BYPASS_EN
  wbq_entry_t [DEPTH-1:0] age_entries;
  logic       [DEPTH-1:0] age_valid;
`endif

  // Ready comes from the registered count only: a pop in the same cycle
  // never opens a slot for a push.
  assign mc_ready   = !q_full;
  // x0 results complete the handshake but are never stored.
  assign push       = mc_valid && mc_ready && (mc_rd != '0);
  assign push_entry = '{rd: mc_rd, wd: mc_wd};

  // A pipeline write to x0 is a free slot the FIFO may use. q_empty is
  // registered, so an entry pushed into an empty FIFO pops next cycle at
  // the earliest.
  assign pipe_win = pipe_we && (pipe_rd != '0);
  assign pop      = !pipe_win && !q_empty;

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
`ifdef WBQ_BYPASS_EN
    ,
    .age_entries(age_entries),
    .age_valid  (age_valid)
`endif
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WE3            <= 1'b0;
      A3             <= '0;
      WD3            <= '0;
      pipe_stall     <= 1'b0;
      starve_cnt_reg <= '0;
    end else begin
      WE3 <= pipe_win || pop;
      // With no writer, A3/WD3 keep their last value.
      if (pipe_win) begin
        A3  <= pipe_rd;
        WD3 <= pipe_wd;
      end else if (pop) begin
        A3  <= head.rd;
        WD3 <= head.wd;
      end

      // The cycle that would bring the count to STARVE_MAX raises the
      // stall pulse instead and restarts the count.
      if (q_empty || pop) begin
        starve_cnt_reg <= '0;
        pipe_stall     <= 1'b0;
      end else if (starve_cnt_reg == SW'(STARVE_MAX-1)) begin
        starve_cnt_reg <= '0;
        pipe_stall     <= 1'b1;
      end else begin
        starve_cnt_reg <= starve_cnt_reg + SW'(1);
        pipe_stall     <= 1'b0;
      end
    end
  end

`ifdef WBQ_BYPASS_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    byp1_hit  = 1'b0;
    byp2_hit  = 1'b0;
    byp1_data = '0;
    byp2_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (age_valid[k] && (byp_a1 != '0) && (age_entries[k].rd == byp_a1)) begin
        byp1_hit  = 1'b1;
        byp1_data = age_entries[k].wd;
      end
      if (age_valid[k] && (byp_a2 != '0) && (age_entries[k].rd == byp_a2)) begin
        byp2_hit  = 1'b1;
        byp2_data = age_entries[k].wd;
      end
    end
  end
`endif

`ifndef SYNTHESIS
  // Upstream must honour the stall pulse; if it does not, the pipeline
  // still wins the port and this flags the protocol breach.
  a_stall_honoured: assert property (@(posedge clk) disable iff (!rst)
    pipe_stall |-> !pipe_we);
`endif

endmodule
